pipe_hazard_unit: RTL

Parametrised hazard/forwarding controller for the pipelined RISC-V core. It generalises the fixed EX/MEM/WB forwarding unit to a configurable number of post-decode stages and source operands. It keeps its own in-flight scoreboard (rd, regwrite, is_load per stage) and handles load-use stalls, branch flush bubbles and whole-pipe freeze. It sits beside the ID/EX pipe register: it takes the decoded ID-stage instruction and drives stall and registered forward selects for the EX operand muxes.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_match.sv | 54 +++++
 rtl/pipe_hazard_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, select encoding and width helper
// for the pipelined-core hazard/forwarding controller.
package hazard_pkg;

   // Widest register address the scoreboard entry can hold; narrower
   // configurations use the low REG_AW bits and keep the rest at zero.
   localparam int unsigned REG_AW_MAX = 8;

   // Forward-select value meaning "take the operand from the register file".
   localparam int unsigned SEL_RF = 0;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
      logic                  regwrite;
      logic                  is_load;
   } hz_entry_t;

   // Forward-select width: enough to encode stage numbers 1..NSTAGE-1, never below one bit.
   function automatic int unsigned sel_width(input int unsigned nstage);
      int unsigned w;
      w = $clog2(nstage);
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-producer priority encoder for one source operand.
// Scans the forwardable stages (0..NSTAGE-2) and reports whether any of them
// writes the source register, the select of the youngest such stage
// (stage j -> select j+1) and whether that producer is a load.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned SELW   = 2
) (
   input  logic [REG_AW-1:0]      rs_i,
   input  logic                   rs_used_i,
   input  hz_entry_t [NSTAGE-1:0] ent_i,
   output logic                   hit_o,
   output logic [SELW-1:0]        sel_o,
   output logic                   is_load_hit_o
);

   logic [NSTAGE-2:0] match_s;
   logic              hit_s;
   logic [SELW-1:0]   sel_s;
   logic              ld_s;

   // Per-stage match; x0 is hard-wired zero and never has a producer.
   always_comb begin
      match_s = '0;
      for (int j = 0; j < int'(NSTAGE) - 1; j++) begin
         match_s[j] = rs_used_i & (rs_i != '0) & ent_i[j].valid & ent_i[j].regwrite
                      & (ent_i[j].rd[REG_AW-1:0] == rs_i);
      end
   end

   // Oldest-to-youngest sweep so the smallest matching stage wins.
   always_comb begin
      hit_s = 1'b0;
      sel_s = SELW'(SEL_RF);
      ld_s  = 1'b0;
      for (int j = int'(NSTAGE) - 2; j >= 0; j--) begin
         sel_s = match_s[j] ? SELW'(j + 1) : sel_s;
         ld_s  = match_s[j] ? ent_i[j].is_load : ld_s;
         hit_s = hit_s | match_s[j];
      end
   end

   assign hit_o         = hit_s;
   assign sel_o         = sel_s;
   assign is_load_hit_o = ld_s;

   // The last stage and any rd bits above REG_AW are intentionally ignored here.
   logic unused_s;
   assign unused_s = ^ent_i;

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard/forwarding controller beside the ID/EX register.
// Tracks NSTAGE post-decode stages, raises load-use stalls, inserts bubbles
// on flush, honours whole-pipe freeze and registers per-source forward selects
// for the EX operand muxes.
// Optional build macro HZ_PERF_CNT_EN adds saturating stall/flush/forward
// event counters (stall_cnt_o, flush_cnt_o, fwd_cnt_o).
module pipe_hazard_unit
   import hazard_pkg::*;
#(
   parameter  int unsigned NSTAGE   = 3,
   parameter  int unsigned NSRC     = 2,
   parameter  int unsigned REG_AW   = 5,
   parameter  int unsigned LD_STAGE = 2,
   localparam int unsigned SELW     = sel_width(NSTAGE)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   id_valid_i,
   input  logic [NSRC*REG_AW-1:0] id_rs_i,
   input  logic [NSRC-1:0]        id_rs_used_i,
   input  logic [REG_AW-1:0]      id_rd_i,
   input  logic                   id_regwrite_i,
   input  logic                   id_is_load_i,
   input  logic                   freeze_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   issue_o,
   output logic [NSRC*SELW-1:0]   fwd_sel_o,
   output logic [NSTAGE-1:0]      stage_valid_o,
   output logic [REG_AW-1:0]      wb_rd_o,
   output logic                   wb_regwrite_o
`ifdef HZ_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cnt_o,
   output logic [31:0]            flush_cnt_o,
   output logic [31:0]            fwd_cnt_o
`endif
);

   hz_entry_t [NSTAGE-1:0] ent_r;
   logic [NSRC*SELW-1:0]   fwd_sel_r;
   logic [NSRC*SELW-1:0]   sel_all_s;
   logic [NSRC-1:0]        hit_s;
   logic [NSRC-1:0]        ld_hit_s;
   logic [NSRC-1:0]        ld_use_s;
   logic                   stall_s;
   logic                   issue_s;
   hz_entry_t              new_ent_s;

   // One youngest-match encoder per source; a load hit is a hazard only when
   // its data is not yet available at the forwarding stage it sits in.
   for (genvar s = 0; s < NSRC; s++) begin : g_src
      hazard_match #(
         .NSTAGE (NSTAGE),
         .REG_AW (REG_AW),
         .SELW   (SELW)
      ) u_match (
         .rs_i          (id_rs_i[s*REG_AW +: REG_AW]),
         .rs_used_i     (id_rs_used_i[s]),
         .ent_i         (ent_r),
         .hit_o         (hit_s[s]),
         .sel_o         (sel_all_s[s*SELW +: SELW]),
         .is_load_hit_o (ld_hit_s[s])
      );

      assign ld_use_s[s] = hit_s[s] & ld_hit_s[s]
                           & (32'(sel_all_s[s*SELW +: SELW]) < LD_STAGE);
   end

   // Flush wins over stall: the killed instruction must not hold the front end.
   assign stall_s = id_valid_i & ~flush_i & (|ld_use_s);
   assign issue_s = id_valid_i & ~stall_s & ~flush_i & ~freeze_i;

   // Scoreboard entry for the ID instruction, or a bubble when nothing issues.
   always_comb begin
      new_ent_s = '0;
      if (issue_s) begin
         new_ent_s.valid              = 1'b1;
         new_ent_s.rd[REG_AW-1:0]     = id_rd_i;
         new_ent_s.regwrite           = id_regwrite_i;
         new_ent_s.is_load            = id_is_load_i;
      end else begin
         new_ent_s = '0;
      end
   end

   // Advance the tracked pipe and latch the EX-stage selects unless frozen.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ent_r     <= '0;
         fwd_sel_r <= '0;
      end else if (!freeze_i) begin
         for (int j = int'(NSTAGE) - 1; j >= 1; j--) begin
            ent_r[j] <= ent_r[j-1];
         end
         ent_r[0]  <= new_ent_s;
         fwd_sel_r <= issue_s ? sel_all_s : '0;
      end else begin
         ent_r     <= ent_r;
         fwd_sel_r <= fwd_sel_r;
      end
   end

   // Gather per-stage valid bits for observation.
   always_comb begin
      stage_valid_o = '0;
      for (int j = 0; j < int'(NSTAGE); j++) begin
         stage_valid_o[j] = ent_r[j].valid;
      end
   end

   assign stall_o       = stall_s;
   assign issue_o       = issue_s;
   assign fwd_sel_o     = fwd_sel_r;
   assign wb_rd_o       = ent_r[NSTAGE-1].rd[REG_AW-1:0];
   assign wb_regwrite_o = ent_r[NSTAGE-1].valid & ent_r[NSTAGE-1].regwrite;

   // Load flag of the last stage and spare rd bits are carried but not consumed.
   logic unused_s;
   assign unused_s = ^ent_r;

`ifdef HZ_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;
   logic [31:0] fwd_cnt_r;

   // Saturating event counters; frozen cycles are not counted as stalls or flushes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
         fwd_cnt_r   <= 32'd0;
      end else begin
         if (stall_s && !freeze_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush_i && !freeze_i && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
         if (issue_s && (sel_all_s != '0) && (fwd_cnt_r != 32'hFFFF_FFFF)) begin
            fwd_cnt_r <= fwd_cnt_r + 32'd1;
         end else begin
            fwd_cnt_r <= fwd_cnt_r;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
   assign fwd_cnt_o   = fwd_cnt_r;
`else
   // Performance counters not built in this configuration.
`endif

endmodule
